// File: rtl/cmp_share_arbiter_pkg.sv
// Shared FSM encoding for the shared less-than comparator arbiter.
package cmp_share_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    CMP   = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/lt_comparator.sv
// Purely combinational A < B; SIGNED selects two's-complement ordering.
module lt_comparator #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt
);

  generate
    if (SIGNED != 0) begin : g_signed
      assign lt = $signed(a) < $signed(b);
    end else begin : g_unsigned
      assign lt = a < b;
    end
  endgenerate

endmodule

// File: rtl/cmp_share_arbiter.sv
// Round-robin sharing of one A<B comparator between N_REQ requesters.
// One operation takes four cycles: pick, latch operands, compare, done.
module cmp_share_arbiter
  import cmp_share_arbiter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int N_REQ  = 2,
  parameter int SIGNED = 0,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WIDTH-1:0]     a_flat,
  input  logic [N_REQ*WIDTH-1:0]     b_flat,
  output logic [N_REQ-1:0]           gnt,
  output logic                       done,
  output logic                       result,
  output logic [$clog2(N_REQ)-1:0]   result_id,
  output logic                       busy,
  output logic [CNT_W-1:0]           op_count
);

  localparam int IDW = $clog2(N_REQ);

  state_e           state, state_n;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   rr_ptr;
  logic [WIDTH-1:0] op_a, op_b;
  logic             lt;

  // First set request bit at or above ptr, wrapping around.
  function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [IDW-1:0]   ptr);
    logic [IDW-1:0] w;
    logic           found;
    int             idx;
    w     = ptr;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && r[idx]) begin
        found = 1'b1;
        w     = IDW'(idx);
      end
    end
    return w;
  endfunction

  lt_comparator #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_lt (
    .a  (op_a),
    .b  (op_b),
    .lt (lt)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state: fixed four-step walk once a request is seen.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (|req) state_n = LATCH;
      LATCH:   state_n = CMP;
      CMP:     state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath and registered outputs; done/gnt trail the DONE state by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      winner    <= '0;
      rr_ptr    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      gnt       <= '0;
      done      <= 1'b0;
      result    <= 1'b0;
      result_id <= '0;
      busy      <= 1'b0;
      op_count  <= '0;
    end else begin
      done <= (state == DONE);
      busy <= (state_n != IDLE);
      case (state)
        IDLE: begin
          gnt <= '0;
          if (|req) winner <= rr_pick(req, rr_ptr);
        end
        LATCH: begin
          op_a <= a_flat[int'(winner)*WIDTH +: WIDTH];
          op_b <= b_flat[int'(winner)*WIDTH +: WIDTH];
          gnt  <= N_REQ'(1) << winner;
        end
        CMP: begin
          result    <= lt;
          result_id <= winner;
        end
        DONE: begin
          if (op_count != {CNT_W{1'b1}}) op_count <= op_count + 1'b1;
          rr_ptr <= (winner == IDW'(N_REQ-1)) ? '0 : winner + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed bench: an unsigned/16-bit-count DUT and a signed/2-bit-count DUT
// share stimulus; a transaction-age model predicts every output each cycle.
module tb_cmp_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] a_flat, b_flat;

  logic [1:0]  gnt0, gnt1;
  logic        done0, done1, res0, res1, busy0, busy1;
  logic [0:0]  id0, id1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cmp_share_arbiter #(.WIDTH(8), .N_REQ(2), .SIGNED(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .gnt(gnt0), .done(done0), .result(res0), .result_id(id0),
    .busy(busy0), .op_count(cnt0));

  cmp_share_arbiter #(.WIDTH(8), .N_REQ(2), .SIGNED(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .gnt(gnt1), .done(done1), .result(res1), .result_id(id1),
    .busy(busy1), .op_count(cnt1));

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an operation is an age counter from the pick edge (age 1) to the
  // edge that shows done (age 4); the next pick may happen at the following edge.
  int m_on = 0, m_act = 0, m_age = 0, m_win = 0, m_ptr = 0;
  int m_a = 0, m_b = 0, m_res_u = 0, m_res_s = 0, m_id = 0, m_cnt16 = 0, m_cnt2 = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_on = 1; m_act = 0; m_age = 0; m_win = 0; m_ptr = 0;
      m_a = 0; m_b = 0; m_res_u = 0; m_res_s = 0; m_id = 0; m_cnt16 = 0; m_cnt2 = 0;
    end else if (m_act != 0 && m_age < 4) begin
      m_age++;
      if (m_age == 2) begin
        m_a = int'(a_flat >> (8 * m_win)) & 255;
        m_b = int'(b_flat >> (8 * m_win)) & 255;
      end
      if (m_age == 3) begin
        m_res_u = (m_a < m_b) ? 1 : 0;
        m_res_s = (((m_a >= 128) ? m_a - 256 : m_a) < ((m_b >= 128) ? m_b - 256 : m_b)) ? 1 : 0;
        m_id    = m_win;
      end
      if (m_age == 4) begin
        m_cnt16 = (m_cnt16 == 65535) ? 65535 : m_cnt16 + 1;
        m_cnt2  = (m_cnt2 == 3) ? 3 : m_cnt2 + 1;
        m_ptr   = (m_win + 1) % 2;
      end
    end else begin
      m_act = 0;
      if (req != 2'b00) begin
        m_win = req[m_ptr] ? m_ptr : (m_ptr + 1) % 2;
        m_act = 1;
        m_age = 1;
      end
    end
  end

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (m_on != 0) begin
      int eg, ed, eb;
      eg = (m_act != 0 && m_age >= 2) ? (1 << m_win) : 0;
      ed = (m_act != 0 && m_age == 4) ? 1 : 0;
      eb = (m_act != 0 && m_age <= 3) ? 1 : 0;
      chk("m_gnt0", int'(gnt0), eg);
      chk("m_gnt1", int'(gnt1), eg);
      chk("m_done0", int'(done0), ed);
      chk("m_done1", int'(done1), ed);
      chk("m_busy0", int'(busy0), eb);
      chk("m_busy1", int'(busy1), eb);
      chk("m_res0", int'(res0), m_res_u);
      chk("m_res1", int'(res1), m_res_s);
      chk("m_id0", int'(id0), m_id);
      chk("m_id1", int'(id1), m_id);
      chk("m_cnt0", int'(cnt0), m_cnt16);
      chk("m_cnt1", int'(cnt1), m_cnt2);
    end
  end

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done0 && cyc < 12);
    if (!done0) chk("done_timeout", 0, 1);
  endtask

  // One operation on requester id with literal expectations for both DUTs.
  task automatic run_op(input int id, input logic [7:0] a, input logic [7:0] b,
                        input int e_u, input int e_s, input int e_cnt);
    int cyc;
    @(negedge clk);
    a_flat[id*8 +: 8] = a;
    b_flat[id*8 +: 8] = b;
    req = 2'b01 << id;
    wait_done(cyc);
    chk("lat", cyc, 4);
    chk("res_u", int'(res0), e_u);
    chk("res_s", int'(res1), e_s);
    chk("res_id", int'(id0), id);
    chk("cnt_u", int'(cnt0), e_cnt);
    req = 2'b00;
  endtask

  initial begin
    int cyc, prev;
    rst = 1'b1; req = 2'b11; a_flat = '0; b_flat = '0;

    // Reset held two cycles with both requesting.
    repeat (2) begin
      @(negedge clk);
      chk("rst_gnt", int'(gnt0), 0);
      chk("rst_done", int'(done0), 0);
      chk("rst_busy", int'(busy0), 0);
      chk("rst_cnt", int'(cnt0), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_gnt_early", int'(gnt0), 0);
    @(negedge clk);
    chk("post_rst_gnt", int'(gnt0), 1);
    wait_done(cyc);
    chk("first_id", int'(id0), 0);
    chk("first_cnt", int'(cnt0), 1);
    req = 2'b00;

    // Single-requester compares (unsigned result, signed result).
    run_op(0, 8'hFF, 8'h00, 0, 1, 2);
    run_op(0, 8'h00, 8'h01, 1, 1, 3);
    run_op(0, 8'hAF, 8'hFF, 1, 1, 4);
    run_op(0, 8'h80, 8'h7F, 0, 1, 5);
    run_op(0, 8'h55, 8'h55, 0, 0, 6);
    run_op(1, 8'h4F, 8'h37, 0, 0, 7);
    chk("sat_cnt", int'(cnt1), 3);

    // Contention: both held, grants must alternate starting at 0.
    @(negedge clk);
    a_flat = {8'hDF, 8'hFD};
    b_flat = {8'hF7, 8'hFF};
    req = 2'b11;
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      wait_done(cyc);
      chk("cont_id", int'(id0), k % 2);
      chk("cont_res_u", int'(res0), 1);
      chk("cont_res_s", int'(res1), 1);
      chk("cont_no_repeat", (int'(id0) != prev) ? 1 : 0, 1);
      prev = int'(id0);
    end
    req = 2'b00;
    chk("cont_cnt", int'(cnt0), 11);

    // Operand change and req drop after latch.
    @(negedge clk);
    a_flat[7:0] = 8'h10; b_flat[7:0] = 8'h20; req = 2'b01;
    repeat (2) @(negedge clk);
    a_flat[7:0] = 8'hFF; req = 2'b00;
    wait_done(cyc);
    chk("drop_res_u", int'(res0), 1);
    chk("drop_res_s", int'(res1), 1);
    chk("drop_cnt", int'(cnt0), 12);
    @(negedge clk);
    chk("drop_gnt_clear", int'(gnt0), 0);
    chk("sat_cnt_final", int'(cnt1), 3);

    // Reset while in CMP: no done, back to idle.
    a_flat[7:0] = 8'h01; b_flat[7:0] = 8'h02; req = 2'b01;
    repeat (2) @(negedge clk);
    chk("abort_busy_pre", int'(busy0), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req = 2'b00;
    chk("abort_busy", int'(busy0), 0);
    chk("abort_gnt", int'(gnt0), 0);
    chk("abort_cnt", int'(cnt0), 0);
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_done", int'(done0), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
